// File: rtl/inst_trace_fifo.sv
// Instruction trace FIFO: captures retiring instructions into a circular buffer for a consumer.
// Overflow policy: define TRACE_OVERWRITE_EN to overwrite the oldest entry, otherwise new captures are dropped.
module inst_trace_fifo #(
  parameter int DEPTH    = 16,
  parameter int SKIP_NOP = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic [39:0]              in_ascii,
  input  logic                     freeze,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [39:0]              out_ascii,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  logic [31:0]   pc_mem_r    [DEPTH];
  logic [31:0]   instr_mem_r [DEPTH];
  logic [39:0]   ascii_mem_r [DEPTH];

  logic [AW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CW-1:0] count_r, count_nxt_s;
  logic [15:0]   drop_r;
  logic          valid_r;
  logic          capture_s, pop_s, full_s, wr_en_s, drop_inc_s;

  assign capture_s = in_valid && !freeze &&
                     !((SKIP_NOP != 32'sd0) && (in_instr == 32'h0000_0000));
  assign pop_s     = valid_r && out_ready;
  assign full_s    = (count_r == FULL_CNT);

  // Next pointer/count/drop decisions for every capture/pop combination
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    wr_en_s      = 1'b0;
    drop_inc_s   = 1'b0;
    case ({capture_s, pop_s})
      2'b11: begin
        // When full the write slot equals the slot being freed by the pop
        wr_en_s      = 1'b1;
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end
      2'b10: begin
        if (!full_s) begin
          wr_en_s      = 1'b1;
          wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
          count_nxt_s  = count_r + CNT_ONE;
        end else begin
`ifdef TRACE_OVERWRITE_EN
          wr_en_s      = 1'b1;
          wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
          rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
`endif
          drop_inc_s   = 1'b1;
        end
      end
      2'b01: begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        count_nxt_s  = count_r - CNT_ONE;
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Control state: pointers, occupancy, valid flag and saturating drop counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      drop_r   <= 16'h0000;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      valid_r  <= (count_nxt_s != '0);
      if (drop_inc_s && (drop_r != 16'hFFFF)) begin
        drop_r <= drop_r + 16'h0001;
      end
    end
  end

  // Entry storage; deliberately not reset, contents are meaningless until captured
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      pc_mem_r[wr_ptr_r]    <= in_pc;
      instr_mem_r[wr_ptr_r] <= in_instr;
      ascii_mem_r[wr_ptr_r] <= in_ascii;
    end
  end

  assign out_valid = valid_r;
  assign out_pc    = pc_mem_r[rd_ptr_r];
  assign out_instr = instr_mem_r[rd_ptr_r];
  assign out_ascii = ascii_mem_r[rd_ptr_r];
  assign count     = count_r;
  assign drop_cnt  = drop_r;

endmodule

// File: tb/tb_inst_trace_fifo.sv
// Directed self-checking bench for inst_trace_fifo; a second instance runs with SKIP_NOP=0.
module tb_inst_trace_fifo;

  localparam logic [39:0] ASC_ADDIU = 40'h41_44_44_49_55;
  localparam logic [39:0] ASC_NOP   = 40'h00_00_4E_4F_50;
`ifdef TRACE_OVERWRITE_EN
  localparam int OVF_OFS = 4;
`else
  localparam int OVF_OFS = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn, in_valid, freeze, out_ready;
  logic [31:0] in_pc, in_instr;
  logic [39:0] in_ascii;

  logic        out_valid, n_out_valid;
  logic [31:0] out_pc, out_instr, n_out_pc, n_out_instr;
  logic [39:0] out_ascii, n_out_ascii;
  logic [4:0]  count, n_count;
  logic [15:0] drop_cnt, n_drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_trace_fifo #(.DEPTH(16), .SKIP_NOP(1)) u_dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_ascii(in_ascii), .freeze(freeze),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_ascii(out_ascii), .count(count),
    .drop_cnt(drop_cnt)
  );

  inst_trace_fifo #(.DEPTH(16), .SKIP_NOP(0)) u_nop (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_ascii(in_ascii), .freeze(freeze),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc),
    .out_instr(n_out_instr), .out_ascii(n_out_ascii), .count(n_count),
    .drop_cnt(n_drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    freeze    = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = ins;
    in_ascii = ASC_ADDIU;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    in_pc    = 32'h0;
    in_instr = 32'h0;
    in_ascii = 40'h0;
    do_reset();
    chk("rst_count", count, 5'd0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_drop", drop_cnt, 16'd0);

    // basic capture while empty with out_ready high: no pop in the capture cycle
    in_valid = 1'b1; in_pc = 32'hBFC0_0000; in_instr = 32'h2402_0001;
    in_ascii = ASC_ADDIU; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("cap_valid", out_valid, 1'b1);
    chk("cap_count", count, 5'd1);
    chk("cap_pc", out_pc, 32'hBFC0_0000);
    chk("cap_instr", out_instr, 32'h2402_0001);
    chk("cap_ascii", out_ascii, ASC_ADDIU);
    step();
    out_ready = 1'b0;
    chk("pop_count", count, 5'd0);
    chk("pop_valid", out_valid, 1'b0);

    // NOP filtering
    do_reset();
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'h0; in_ascii = ASC_NOP;
    step();
    in_valid = 1'b0;
    chk("nop_skip_count", count, 5'd0);
    chk("nop_skip_valid", out_valid, 1'b0);
    chk("nop_keep_count", n_count, 5'd1);
    chk("nop_keep_ascii", n_out_ascii, ASC_NOP);

    // overflow with 17 captures
    do_reset();
    for (int i = 0; i < 17; i++) push(32'(i * 4), 32'h1000 + 32'(i));
    chk("ovf_count", count, 5'd16);
    chk("ovf_drop", drop_cnt, 16'd1);
    chk("ovf_head", out_pc, 32'(OVF_OFS));
    step();
    chk("ovf_stable", out_pc, 32'(OVF_OFS));
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_drain%0d", i), out_pc, 32'(OVF_OFS + i * 4));
      step();
    end
    out_ready = 1'b0;
    chk("ovf_empty", count, 5'd0);

    // simultaneous capture and pop while full
    do_reset();
    for (int i = 0; i < 16; i++) push(32'(i * 4), 32'h2000 + 32'(i));
    chk("fp_full", count, 5'd16);
    in_valid = 1'b1; in_pc = 32'h0000_0ABC; in_instr = 32'h3000; out_ready = 1'b1;
    chk("fp_popped", out_pc, 32'h0);
    step();
    in_valid = 1'b0;
    chk("fp_count", count, 5'd16);
    chk("fp_drop", drop_cnt, 16'd0);
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("fp_drain%0d", i), out_pc, (i < 16) ? 32'(i * 4) : 32'h0000_0ABC);
      step();
    end
    out_ready = 1'b0;
    chk("fp_empty", count, 5'd0);

    // freeze blocks capture but not popping
    do_reset();
    for (int i = 0; i < 7; i++) push(32'h200 + 32'(i * 4), 32'h4000 + 32'(i));
    freeze = 1'b1; in_valid = 1'b1; in_pc = 32'h999; in_instr = 32'h1;
    repeat (5) step();
    chk("frz_count", count, 5'd7);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("frz_pop%0d", i), out_pc, 32'h200 + 32'(i * 4));
      step();
    end
    out_ready = 1'b0; freeze = 1'b0; in_valid = 1'b0;
    chk("frz_after", count, 5'd4);

    // asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) push(32'h300 + 32'(i * 4), 32'h5000 + 32'(i));
    chk("ar_pre", count, 5'd7);
    in_valid = 1'b1; in_pc = 32'h400; in_instr = 32'h6000;
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_count", count, 5'd0);
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_drop", drop_cnt, 16'd0);
    step();
    in_valid = 1'b0;
    resetn = 1'b1;
    step();
    chk("ar_hold", count, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
